// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- asynchronous serial transmitter with optional parity, one or two
// stop bits and an optional line-break generator.
//
// Frame on UART_Tx: start (0), C_UART_DATA_WIDTH data bits LSB first,
// optional parity bit, C_UART_STOP stop bits (1). Every bit lasts
// DIV = C_CLK_FREQ / C_UART_BAUD sysClk cycles.
//
// Compile-time option:
//   UART_TX_BREAK_EN  when defined, txBreak holds the line low (BREAK state)
//                     and is followed by a stop period; when undefined,
//                     txBreak is ignored and no BREAK state exists.
//
// Ports:
//   sysClk     in   single clock, rising edge
//   sysRst     in   synchronous active-high reset
//   dataIn     in   word to transmit (C_UART_DATA_WIDTH bits)
//   dataValid  in   dataIn is valid; taken when dataReady is also 1
//   dataReady  out  transmitter idle and able to accept a word
//   txBreak    in   break request (only honoured with UART_TX_BREAK_EN)
//   txBusy     out  frame or break in progress
//   UART_Tx    out  serial line, idle high, driven from a flop
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx #(
   parameter int C_CLK_FREQ        = 100000000,
   parameter int C_UART_BAUD       = 115200,
   parameter int C_UART_DATA_WIDTH = 8,
   parameter int C_UART_PARITY     = 1,
   parameter int C_UART_STOP       = 1
) (
   input  logic                         sysClk,
   input  logic                         sysRst,
   input  logic [C_UART_DATA_WIDTH-1:0] dataIn,
   input  logic                         dataValid,
   output logic                         dataReady,
   input  logic                         txBreak,
   output logic                         txBusy,
   output logic                         UART_Tx
);

   localparam int DIV   = C_CLK_FREQ / C_UART_BAUD;
   localparam int CNT_W = $clog2(DIV);
   localparam int IDX_W = $clog2(C_UART_DATA_WIDTH);
   localparam bit PAR_EN = (C_UART_PARITY != 0);

   localparam logic [CNT_W-1:0] BAUD_RELOAD   = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO      = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_ZERO      = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_ONE       = IDX_W'(1);
   localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(C_UART_DATA_WIDTH - 1);
   localparam logic [IDX_W-1:0] LAST_STOP_IDX = IDX_W'(C_UART_STOP - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
`ifdef UART_TX_BREAK_EN
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
`else
      ST_STOP   = 3'd4
`endif
   } state_t;

   // Parity bit for a data word: even mode sends the XOR, odd mode its inverse.
   function automatic logic f_parity(input logic [C_UART_DATA_WIDTH-1:0] d);
      logic p;
      p = ^d;
      if (C_UART_PARITY == 2) begin
         return ~p;
      end else begin
         return p;
      end
   endfunction

   state_t                         r_state;
   state_t                         w_state_nxt;
   logic [CNT_W-1:0]               r_baud;
   logic [CNT_W-1:0]               w_baud_nxt;
   logic [IDX_W-1:0]               r_idx;
   logic [IDX_W-1:0]               w_idx_nxt;
   logic [C_UART_DATA_WIDTH-1:0]   r_shift;
   logic [C_UART_DATA_WIDTH-1:0]   w_shift_nxt;
   logic                           r_par;
   logic                           w_par_nxt;
   logic                           r_tx;
   logic                           w_tx_nxt;
   logic                           r_ready;
   logic                           w_ready_nxt;
   logic                           r_busy;
   logic                           w_brk_req;
   logic                           w_accept;
   logic                           w_baud_done;

`ifdef UART_TX_BREAK_EN
   assign w_brk_req = txBreak;
`else
   // Break generation is compiled out; the port is kept but has no effect.
   logic w_unused_brk;
   assign w_unused_brk = txBreak;
   assign w_brk_req    = 1'b0;
`endif

   // A pending break in IDLE takes priority over a word offered the same cycle.
   assign w_accept    = dataValid & r_ready & ~w_brk_req;
   assign w_baud_done = (r_baud == CNT_ZERO);

   assign dataReady = r_ready;
   assign txBusy    = r_busy;
   assign UART_Tx   = r_tx;

   // Next-state and next-datapath logic; the line value is computed for the
   // state being entered so that UART_Tx can come straight from a flop.
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_par_nxt   = r_par;
      w_tx_nxt    = r_tx;

      case (r_state)
         ST_IDLE: begin
            w_tx_nxt = 1'b1;
            if (w_accept) begin
               w_state_nxt = ST_START;
               w_shift_nxt = dataIn;
               w_par_nxt   = f_parity(dataIn);
               w_baud_nxt  = BAUD_RELOAD;
               w_idx_nxt   = IDX_ZERO;
               w_tx_nxt    = 1'b0;
            end
`ifdef UART_TX_BREAK_EN
            else if (txBreak) begin
               w_state_nxt = ST_BREAK;
               w_tx_nxt    = 1'b0;
            end
`endif
            else begin
               w_state_nxt = ST_IDLE;
            end
         end

         ST_START: begin
            if (w_baud_done) begin
               w_state_nxt = ST_DATA;
               w_baud_nxt  = BAUD_RELOAD;
               w_idx_nxt   = IDX_ZERO;
               w_tx_nxt    = r_shift[0];
            end else begin
               w_baud_nxt  = r_baud - CNT_ONE;
            end
         end

         ST_DATA: begin
            if (w_baud_done) begin
               w_baud_nxt = BAUD_RELOAD;
               if (r_idx == LAST_DATA_IDX) begin
                  w_idx_nxt = IDX_ZERO;
                  if (PAR_EN) begin
                     w_state_nxt = ST_PARITY;
                     w_tx_nxt    = r_par;
                  end else begin
                     w_state_nxt = ST_STOP;
                     w_tx_nxt    = 1'b1;
                  end
               end else begin
                  // Shift first so the next bit to send is always at [0].
                  w_idx_nxt   = r_idx + IDX_ONE;
                  w_shift_nxt = {1'b0, r_shift[C_UART_DATA_WIDTH-1:1]};
                  w_tx_nxt    = r_shift[1];
               end
            end else begin
               w_baud_nxt = r_baud - CNT_ONE;
            end
         end

         ST_PARITY: begin
            if (w_baud_done) begin
               w_state_nxt = ST_STOP;
               w_baud_nxt  = BAUD_RELOAD;
               w_idx_nxt   = IDX_ZERO;
               w_tx_nxt    = 1'b1;
            end else begin
               w_baud_nxt  = r_baud - CNT_ONE;
            end
         end

         ST_STOP: begin
            w_tx_nxt = 1'b1;
            if (w_baud_done) begin
               // r_idx counts stop bits here, reused from the data phase.
               if (r_idx == LAST_STOP_IDX) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_idx_nxt  = r_idx + IDX_ONE;
                  w_baud_nxt = BAUD_RELOAD;
               end
            end else begin
               w_baud_nxt = r_baud - CNT_ONE;
            end
         end

`ifdef UART_TX_BREAK_EN
         ST_BREAK: begin
            if (txBreak) begin
               w_tx_nxt = 1'b0;
            end else begin
               w_state_nxt = ST_STOP;
               w_baud_nxt  = BAUD_RELOAD;
               w_idx_nxt   = IDX_ZERO;
               w_tx_nxt    = 1'b1;
            end
         end
`endif

         default: begin
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = 1'b1;
         end
      endcase

      w_ready_nxt = (w_state_nxt == ST_IDLE) & ~w_brk_req;
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge sysClk) begin
      if (sysRst) begin
         r_state <= ST_IDLE;
         r_baud  <= CNT_ZERO;
         r_idx   <= IDX_ZERO;
         r_shift <= {C_UART_DATA_WIDTH{1'b0}};
         r_par   <= 1'b0;
         r_tx    <= 1'b1;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
         r_par   <= w_par_nxt;
         r_tx    <= w_tx_nxt;
         r_ready <= w_ready_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx.
// DUT A: 8 data bits, even parity, 1 stop. DUT B: 8 data bits, odd parity,
// 2 stops. Both at DIV = 800/100 = 8 cycles per bit.
// Expected line levels are queued cycle by cycle when a word is offered and
// popped after every rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_tx;

   localparam int DIV = 8;

   logic       sysClk = 1'b0;
   logic       rst_a, rst_b;
   logic [7:0] din_a, din_b;
   logic       vld_a, vld_b, brk_a, brk_b;
   logic       rdy_a, rdy_b, busy_a, busy_b, tx_a, tx_b;

   int n_tests = 0;
   int n_fail  = 0;
   bit q_a[$];
   bit q_b[$];

   typedef struct {
      logic [7:0] data;
      logic       par;   // expected even-parity bit
   } vec_t;

   vec_t vecs[8];

   always #5 sysClk = ~sysClk;

   uart_tx #(.C_CLK_FREQ(800), .C_UART_BAUD(100), .C_UART_DATA_WIDTH(8),
             .C_UART_PARITY(1), .C_UART_STOP(1)) dut_a (
      .sysClk(sysClk), .sysRst(rst_a), .dataIn(din_a), .dataValid(vld_a),
      .dataReady(rdy_a), .txBreak(brk_a), .txBusy(busy_a), .UART_Tx(tx_a));

   uart_tx #(.C_CLK_FREQ(800), .C_UART_BAUD(100), .C_UART_DATA_WIDTH(8),
             .C_UART_PARITY(2), .C_UART_STOP(2)) dut_b (
      .sysClk(sysClk), .sysRst(rst_b), .dataIn(din_b), .dataValid(vld_b),
      .dataReady(rdy_b), .txBreak(brk_b), .txBusy(busy_b), .UART_Tx(tx_b));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One rising edge, then sample on the falling edge and score the line.
   task automatic tick();
      bit e;
      @(posedge sysClk);
      @(negedge sysClk);
      if (q_a.size() > 0) begin
         e = q_a.pop_front();
         check("line_a", {31'd0, tx_a}, {31'd0, e});
      end
      if (q_b.size() > 0) begin
         e = q_b.pop_front();
         check("line_b", {31'd0, tx_b}, {31'd0, e});
      end
   endtask

   function automatic void push_bit(input bit sel, input bit b, input int n);
      for (int i = 0; i < n; i++) begin
         if (sel) q_b.push_back(b);
         else     q_a.push_back(b);
      end
   endfunction

   function automatic void push_frame(input bit sel, input logic [7:0] d,
                                      input logic par, input int stops);
      push_bit(sel, 1'b0, DIV);
      for (int i = 0; i < 8; i++) push_bit(sel, d[i], DIV);
      push_bit(sel, par, DIV);
      push_bit(sel, 1'b1, stops * DIV);
   endfunction

   function automatic logic rdy_of(input bit sel);
      return sel ? rdy_b : rdy_a;
   endfunction

   function automatic logic busy_of(input bit sel);
      return sel ? busy_b : busy_a;
   endfunction

   function automatic int qsize(input bit sel);
      return sel ? q_b.size() : q_a.size();
   endfunction

   task automatic wait_ready(input bit sel);
      for (int i = 0; i < 200; i++) begin
         if (rdy_of(sel) == 1'b1) break;
         tick();
      end
      check("ready_wait", {31'd0, rdy_of(sel)}, 32'd1);
   endtask

   // Offer one word for a single cycle, then score the frame, the busy/ready
   // window length and the return to idle.
   task automatic send(input bit sel, input logic [7:0] d, input logic par,
                       input int stops, input int len);
      int busy_cnt;
      wait_ready(sel);
      if (sel) begin vld_b = 1'b1; din_b = d; end
      else     begin vld_a = 1'b1; din_a = d; end
      push_frame(sel, d, par, stops);
      tick();
      busy_cnt = (rdy_of(sel) == 1'b0 && busy_of(sel) == 1'b1) ? 1 : 0;
      if (sel) begin vld_b = 1'b0; din_b = ~d; end
      else     begin vld_a = 1'b0; din_a = ~d; end
      while (qsize(sel) > 0) begin
         tick();
         if (rdy_of(sel) == 1'b0 && busy_of(sel) == 1'b1) busy_cnt++;
      end
      check("busy_window", busy_cnt, len);
      tick();
      check("ready_after", {31'd0, rdy_of(sel)}, 32'd1);
      check("busy_after", {31'd0, busy_of(sel)}, 32'd0);
   endtask

   initial begin
      vecs[0] = '{8'h07, 1'b1};
      vecs[1] = '{8'h00, 1'b0};
      vecs[2] = '{8'hFF, 1'b0};
      vecs[3] = '{8'h01, 1'b1};
      vecs[4] = '{8'hA5, 1'b0};
      vecs[5] = '{8'h80, 1'b1};
      vecs[6] = '{8'h6E, 1'b1};
      vecs[7] = '{8'h55, 1'b0};

      rst_a = 1'b1; rst_b = 1'b1;
      din_a = 8'h00; din_b = 8'h00;
      vld_a = 1'b0; vld_b = 1'b0;
      brk_a = 1'b0; brk_b = 1'b0;

      // Reset values while reset is held.
      repeat (4) tick();
      check("rst_tx_a", {31'd0, tx_a}, 32'd1);
      check("rst_busy_a", {31'd0, busy_a}, 32'd0);
      check("rst_ready_a", {31'd0, rdy_a}, 32'd0);
      check("rst_tx_b", {31'd0, tx_b}, 32'd1);
      check("rst_ready_b", {31'd0, rdy_b}, 32'd0);
      rst_a = 1'b0; rst_b = 1'b0;
      tick();
      check("ready_post_rst_a", {31'd0, rdy_a}, 32'd1);
      check("ready_post_rst_b", {31'd0, rdy_b}, 32'd1);

      // 8E1 frames from the vector table; first one is 0x07.
      for (int i = 0; i < 8; i++) begin
         send(1'b0, vecs[i].data, vecs[i].par, 1, 88);
      end

      // 8O2 frame: 0x55 has four ones, odd parity bit is 1, 96 cycles total.
      send(1'b1, 8'h55, 1'b1, 2, 96);

      // Back-to-back with dataValid held high; dataIn changes after each accept.
      wait_ready(1'b0);
      vld_a = 1'b1;
      din_a = 8'hA5;
      push_frame(1'b0, 8'hA5, 1'b0, 1);
      push_bit(1'b0, 1'b1, 1);
      push_frame(1'b0, 8'h3C, 1'b0, 1);
      tick();
      din_a = 8'h3C;
      repeat (89) tick();
      vld_a = 1'b0;
      din_a = 8'hFF;
      while (q_a.size() > 0) tick();
      tick();
      check("b2b_ready_after", {31'd0, rdy_a}, 32'd1);
      push_bit(1'b0, 1'b1, 8);
      repeat (8) tick();

      // Reset during data bit 3 of 0xF0 (bit 3 is 0).
      wait_ready(1'b0);
      vld_a = 1'b1;
      din_a = 8'hF0;
      tick();
      vld_a = 1'b0;
      repeat (33) tick();
      check("bit3_before_rst", {31'd0, tx_a}, 32'd0);
      rst_a = 1'b1;
      tick();
      check("midrst_tx", {31'd0, tx_a}, 32'd1);
      check("midrst_busy", {31'd0, busy_a}, 32'd0);
      check("midrst_ready", {31'd0, rdy_a}, 32'd0);
      rst_a = 1'b0;
      tick();
      check("postrst_ready", {31'd0, rdy_a}, 32'd1);
      check("postrst_tx", {31'd0, tx_a}, 32'd1);
      check("postrst_busy", {31'd0, busy_a}, 32'd0);
      send(1'b0, 8'h81, 1'b0, 1, 88);

      // Break request held for 40 cycles in IDLE.
      wait_ready(1'b0);
      brk_a = 1'b1;
`ifdef UART_TX_BREAK_EN
      for (int i = 0; i < 40; i++) begin
         tick();
         check("brk_low", {31'd0, tx_a}, 32'd0);
         check("brk_ready", {31'd0, rdy_a}, 32'd0);
      end
      brk_a = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("brk_stop_high", {31'd0, tx_a}, 32'd1);
         check("brk_stop_ready", {31'd0, rdy_a}, 32'd0);
      end
      tick();
      check("brk_ready_after", {31'd0, rdy_a}, 32'd1);
`else
      for (int i = 0; i < 40; i++) begin
         tick();
         check("nobrk_line", {31'd0, tx_a}, 32'd1);
         check("nobrk_ready", {31'd0, rdy_a}, 32'd1);
      end
      brk_a = 1'b0;
`endif

      // Word offered right after the break sequence still goes out intact.
      send(1'b0, 8'h3C, 1'b0, 1, 88);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001 The module SHALL have the parameter C_CLK_FREQ, default 100000000, meaning the sysClk frequency in Hz.
- REQ-002 The module SHALL have the parameter C_UART_BAUD, default 115200, meaning the line bit rate in bit/s.
- REQ-003 The module SHALL have the parameter C_UART_DATA_WIDTH, default 8, meaning data bits per frame; legal range 5..9.
- REQ-004 The module SHALL have the parameter C_UART_PARITY, default 1, meaning the parity mode: 0 none, 1 even, 2 odd.
- REQ-005 The module SHALL have the parameter C_UART_STOP, default 1, meaning the stop bit count; legal values 1 or 2.
- REQ-006 The module SHALL have port sysClk, input, 1 bit: the single clock; all logic is on its rising edge.
- REQ-007 The module SHALL have port sysRst, input, 1 bit: reset, synchronous, active-high.
- REQ-008 The module SHALL have port dataIn, input, C_UART_DATA_WIDTH bits: the word to transmit.
- REQ-009 The module SHALL have port dataValid, input, 1 bit: dataIn is valid.
- REQ-010 The module SHALL have port dataReady, output, 1 bit: the transmitter can accept a word.
- REQ-011 The module SHALL have port txBreak, input, 1 bit: break request (see Configuration).
- REQ-012 The module SHALL have port txBusy, output, 1 bit: a frame or break is in progress.
- REQ-013 The module SHALL have port UART_Tx, output, 1 bit: the serial line, idle high.

Function
- REQ-014 Bit period SHALL be DIV = C_CLK_FREQ / C_UART_BAUD sysClk cycles, using integer truncation, with DIV >= 2.
- REQ-015 The baud counter SHALL reload to DIV-1 at each bit start and count down to 0; it SHALL never wrap mid-bit.
- REQ-016 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and BREAK.
- REQ-017 dataReady SHALL be 1 only in IDLE when no break is pending; txBusy SHALL equal NOT(IDLE).
- REQ-018 A word SHALL be accepted when dataValid AND dataReady are 1 on a rising edge.
  - dataIn is registered in that cycle.
  - The FSM moves to START.
  - UART_Tx goes low on the next cycle, so latency is 1 cycle.
- REQ-019 START SHALL hold the line low for DIV cycles, then go to DATA.
- REQ-020 DATA SHALL send C_UART_DATA_WIDTH bits LSB first, each for DIV cycles, using a bit index counter from 0 to C_UART_DATA_WIDTH-1.
- REQ-021 After the last data bit, the FSM SHALL go to PARITY if C_UART_PARITY is not 0, otherwise to STOP.
- REQ-022 The PARITY bit SHALL be:
  - even mode: the XOR of the data bits;
  - odd mode: the inverted XOR of the data bits.
  The bit is held for DIV cycles.
- REQ-023 STOP SHALL hold the line high for C_UART_STOP*DIV cycles, then return to IDLE; dataReady rises on the first IDLE cycle.
- REQ-024 dataValid held high continuously SHALL produce back-to-back frames with no idle gap beyond 1 cycle between the stop end and the next start.
- REQ-025 While txBusy is 1, dataIn and dataValid SHALL be ignored; the registered word SHALL be immune to dataIn changes.
- REQ-026 UART_Tx SHALL be driven from a register so the line is glitch-free.

Reset
- REQ-027 When sysRst is 1 on a rising edge, the module SHALL apply these reset values:
  - state: IDLE;
  - UART_Tx: 1;
  - dataReady: 1 on the cycle after reset deasserts, 0 during reset;
  - txBusy: 0;
  - baud counter, bit index and shift register: 0.
- REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; the line SHALL be high on the next cycle and no partial frame SHALL resume.

Configuration
- REQ-029 The macro UART_TX_BREAK_EN SHALL compile break generation in or out.
- REQ-030 With UART_TX_BREAK_EN defined, the break SHALL behave as follows:
  - txBreak=1 sampled in IDLE enters BREAK, with UART_Tx=0 and dataReady=0.
  - If txBreak and dataValid are both 1 in IDLE, break wins and no word is accepted.
  - txBreak=1 during a frame is deferred until the frame completes.
  - On txBreak=0, the FSM goes to STOP, holds the line high for C_UART_STOP*DIV cycles, then returns to IDLE.
- REQ-031 Without UART_TX_BREAK_EN, the txBreak port SHALL remain present but be ignored, and the BREAK state SHALL not be synthesised.

Verification
Bench parameters: C_CLK_FREQ=800, C_UART_BAUD=100 (DIV=8).
- REQ-032 8E1 frame test: reset 4 cycles, then dataIn=0x07 with dataValid=1 for 1 cycle.
  - Required response: UART_Tx low 1 cycle after acceptance.
  - Then bits 1,1,1,0,0,0,0,0 at 8 cycles each, parity 1, stop high 8 cycles.
  - dataReady=0 for 88 cycles.
- REQ-033 Odd parity and two stop bits test: C_UART_PARITY=2, C_UART_STOP=2, dataIn=0x55.
  - Required response: data bits 1,0,1,0,1,0,1,0, parity 1, stop high 16 cycles; frame length 96 cycles.
- REQ-034 Back-to-back test: dataValid held high, dataIn=0xA5 then 0x3C.
  - Required response: the second start bit begins exactly 1 cycle after the first stop ends.
  - Each word is sampled only at acceptance.
- REQ-035 Reset mid-frame test: sysRst=1 during data bit 3.
  - Required response: UART_Tx=1 the next cycle, txBusy=0, dataReady=1 after reset release.
  - A following word of 0x81 is sent correctly.
- REQ-036 Break test with UART_TX_BREAK_EN defined: txBreak=1 in IDLE for 40 cycles.
  - Required response: UART_Tx=0 for 40 cycles, then high 8 cycles with dataReady=0, then dataReady=1.
  - Without the macro, UART_Tx stays 1 and dataReady stays 1.
